// File: rtl/rvfi_revert_history.sv
// History buffer between the RVFI monitor and the scoreboard: keeps the youngest
// REVERT_MAX retired entries revertable and releases older ones in order.
//
// state | meaning
// RUN   | accept retires and reverts, release entries older than REVERT_MAX
// FLUSH | no retires, reverts rejected, drain every held entry, then back to RUN
module rvfi_revert_history #(
  parameter int NRET       = 2,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  parameter int REVERT_MAX = 4,
  localparam int RW = $clog2(REVERT_MAX + 1),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NRET-1:0]        in_valid_i,
  input  logic [NRET*DATA_W-1:0] in_data_i,
  output logic                   in_ready_o,
  input  logic                   revert_req_i,
  input  logic [RW-1:0]          revert_steps_i,
  output logic                   revert_done_o,
  output logic                   revert_err_o,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o,
  input  logic                   out_ready_i,
  output logic [CW-1:0]          count_o,
  output logic                   overflow_o
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic              pop, rev_ok, steps_ok;
  logic [CW-1:0]     avail, rev_amt, n_wr, count_next;
  logic [PW-1:0]     wr_base, wr_next, rd_next;
  logic [PW-1:0]     slot [NRET];
  logic [NRET-1:0]   we;

  // Same-cycle order: pop on the old state, then revert, then append the new retires.
  always_comb begin
    out_valid_o = (state == RUN) ? (count > CW'(REVERT_MAX)) : (count != '0);
    in_ready_o  = (state == RUN) && (count <= CW'(DEPTH - NRET));
    pop         = out_valid_o && out_ready_i;
    avail       = count - CW'(pop);
    steps_ok    = (revert_steps_i != '0) &&
                  (revert_steps_i <= RW'(REVERT_MAX)) &&
                  (CW'(revert_steps_i) <= avail);
    rev_ok      = revert_req_i && (state == RUN) && steps_ok;
    rev_amt     = rev_ok ? CW'(revert_steps_i) : '0;
    wr_base     = wr_ptr - rev_amt[PW-1:0];
    n_wr        = '0;
    for (int c = 0; c < NRET; c++) begin
      we[c]   = 1'b0;
      slot[c] = wr_base + n_wr[PW-1:0];
      if (in_ready_o && in_valid_i[c]) begin
        we[c] = 1'b1;
        n_wr  = n_wr + CW'(1);
      end
    end
    count_next = count - CW'(pop) - rev_amt + n_wr;
    wr_next    = wr_base + n_wr[PW-1:0];
    rd_next    = rd_ptr + PW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      revert_done_o <= 1'b0;
      revert_err_o  <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      rd_ptr        <= rd_next;
      wr_ptr        <= wr_next;
      count         <= count_next;
      revert_done_o <= rev_ok;
      revert_err_o  <= revert_req_i && !rev_ok;
      if (!in_ready_o && (|in_valid_i))
        overflow_o <= 1'b1;
      case (state)
        RUN:     if (flush_i) state <= FLUSH;
        FLUSH:   if (count_next == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NRET; c++)
      if (we[c])
        mem[slot[c]] <= in_data_i[c*DATA_W +: DATA_W];
  end

  assign out_data_o = mem[rd_ptr];
  assign count_o    = count;

endmodule

// File: tb/tb_rvfi_revert_history.sv
// Directed bench for rvfi_revert_history (NRET=2, DEPTH=8, REVERT_MAX=2) with a
// scoreboard queue of expected released entries checked by a separate monitor.
module tb_rvfi_revert_history;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [1:0]   in_valid_i = '0;
  logic [127:0] in_data_i = '0;
  logic         in_ready_o;
  logic         revert_req_i = 1'b0;
  logic [1:0]   revert_steps_i = '0;
  logic         revert_done_o, revert_err_o;
  logic         flush_i = 1'b0;
  logic         out_valid_o;
  logic [63:0]  out_data_o;
  logic         out_ready_i = 1'b0;
  logic [3:0]   count_o;
  logic         overflow_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  rvfi_revert_history #(.NRET(2), .DATA_W(64), .DEPTH(8), .REVERT_MAX(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .revert_req_i(revert_req_i), .revert_steps_i(revert_steps_i),
    .revert_done_o(revert_done_o), .revert_err_o(revert_err_o), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] d(input int i);
    return {32'hC0DE_F00D, 32'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                    input logic exp_acc);
    in_valid_i = v;
    in_data_i  = {d1, d0};
    chk("in_ready", 64'(in_ready_o), 64'(exp_acc));
    if (exp_acc) begin
      if (v[0]) sb.push_back(d0);
      if (v[1]) sb.push_back(d1);
    end
    cyc();
    in_valid_i = '0;
  endtask

  task automatic rev(input logic [1:0] steps, input logic exp_ok);
    revert_req_i   = 1'b1;
    revert_steps_i = steps;
    if (exp_ok) repeat (int'(steps)) void'(sb.pop_back());
    cyc();
    revert_req_i = 1'b0;
    chk("revert_done", 64'(revert_done_o), 64'(exp_ok));
    chk("revert_err", 64'(revert_err_o), 64'(!exp_ok));
  endtask

  task automatic flush_drain();
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    for (int i = 0; i < 40 && count_o != 0; i++) cyc();
    chk("drain_count", 64'(count_o), 64'd0);
    chk("drain_back_to_run", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b0;
  endtask

  // Every release the DUT makes must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %0h expected no release (scoreboard empty)", out_data_o);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data_o !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", out_data_o, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_done", 64'(revert_done_o), 64'd0);
    chk("rst_err", 64'(revert_err_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Packed writes with a channel gap; lag of REVERT_MAX before release.
    out_ready_i = 1'b1;
    wr(2'b11, d(1), d(2), 1'b1);
    chk("s1_count2", 64'(count_o), 64'd2);
    chk("s1_hold", 64'(out_valid_o), 64'd0);
    wr(2'b10, d(99), d(3), 1'b1);
    chk("s1_count3", 64'(count_o), 64'd3);
    chk("s1_valid", 64'(out_valid_o), 64'd1);
    cyc();
    chk("s1_count_settle", 64'(count_o), 64'd2);
    chk("s1_valid_drop", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    flush_drain();

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 4; i++) wr(2'b11, d(20 + 2*i), d(21 + 2*i), 1'b1);
    chk("s2_full_count", 64'(count_o), 64'd8);
    wr(2'b11, d(90), d(91), 1'b0);
    chk("s2_overflow", 64'(overflow_o), 64'd1);
    chk("s2_count_kept", 64'(count_o), 64'd8);
    out_ready_i = 1'b1;
    cyc();
    chk("s2_count7", 64'(count_o), 64'd7);
    chk("s2_not_ready7", 64'(in_ready_o), 64'd0);
    cyc();
    chk("s2_ready6", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b0;
    flush_drain();
    chk("s2_overflow_sticky", 64'(overflow_o), 64'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("s2_overflow_clear", 64'(overflow_o), 64'd0);

    // Revert 2 of W,X,Y,Z; next write lands after X.
    wr(2'b11, d(40), d(41), 1'b1);
    wr(2'b11, d(42), d(43), 1'b1);
    rev(2'd2, 1'b1);
    chk("s3_count", 64'(count_o), 64'd2);
    cyc();
    chk("s3_done_one_cycle", 64'(revert_done_o), 64'd0);
    wr(2'b01, d(44), d(98), 1'b1);
    chk("s3_count_e", 64'(count_o), 64'd3);
    flush_drain();

    // Rejected reverts: too many, zero, out of range.
    wr(2'b01, d(50), d(97), 1'b1);
    rev(2'd2, 1'b0);
    chk("s4_count_kept", 64'(count_o), 64'd1);
    cyc();
    chk("s4_err_one_cycle", 64'(revert_err_o), 64'd0);
    rev(2'd0, 1'b0);
    wr(2'b11, d(51), d(52), 1'b1);
    rev(2'd3, 1'b0);
    chk("s4_count_range", 64'(count_o), 64'd3);
    flush_drain();

    // Pop + revert 1 + write 2 in one cycle.
    wr(2'b11, d(60), d(61), 1'b1);
    wr(2'b11, d(62), d(63), 1'b1);
    out_ready_i    = 1'b1;
    revert_req_i   = 1'b1;
    revert_steps_i = 2'd1;
    in_valid_i     = 2'b11;
    in_data_i      = {d(65), d(64)};
    void'(sb.pop_back());
    sb.push_back(d(64));
    sb.push_back(d(65));
    cyc();
    out_ready_i  = 1'b0;
    revert_req_i = 1'b0;
    in_valid_i   = '0;
    chk("s5_count", 64'(count_o), 64'd4);
    chk("s5_done", 64'(revert_done_o), 64'd1);
    flush_drain();

    // Flush with nothing held: one FLUSH cycle, then RUN.
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("s6_empty_flush_busy", 64'(in_ready_o), 64'd0);
    cyc();
    chk("s6_empty_flush_run", 64'(in_ready_o), 64'd1);

    // Revert and reset during a flush.
    wr(2'b11, d(70), d(71), 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("s6_flush_not_ready", 64'(in_ready_o), 64'd0);
    rev(2'd1, 1'b0);
    chk("s6_flush_count", 64'(count_o), 64'd2);
    out_ready_i = 1'b1;
    cyc();
    out_ready_i = 1'b0;
    chk("s6_flush_count1", 64'(count_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("s6_async_rst_count", 64'(count_o), 64'd0);
    chk("s6_async_rst_valid", 64'(out_valid_o), 64'd0);
    sb.delete();
    cyc();
    rst_i = 1'b0;
    chk("s6_rst_run", 64'(in_ready_o), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_revert_history.md
Name: rvfi_revert_history

Overview:
- Parametrised multi-retire history buffer between the RVFI monitor and the reference-model scoreboard.
- Holds recently retired trace entries so that late interrupt/debug decisions can revert the youngest N steps before comparison.
- Releases an entry to the scoreboard only once it can no longer be reverted (age > REVERT_MAX) or on flush.
- Generalises single-step revert to NRET retire channels, configurable depth and a bounded revert window.

Parameters:
- NRET, 2, retire channels accepted per cycle (1..4).
- DATA_W, 64, width of one packed trace entry.
- DEPTH, 16, history entries; power of 2, DEPTH >= REVERT_MAX+NRET.
- REVERT_MAX, 4, maximum revertable steps; also the commit lag.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  NRET  per-channel retire valid
- in_data_i  in  NRET*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- in_ready_o  out  1  free entries >= NRET and state RUN
- revert_req_i  in  1  revert request, single-cycle
- revert_steps_i  in  RW=$clog2(REVERT_MAX+1)  number of youngest entries to drop
- revert_done_o  out  1  registered pulse, revert applied
- revert_err_o  out  1  registered pulse, revert rejected
- flush_i  in  1  make all held entries drainable
- out_valid_o  out  1  oldest entry committable
- out_data_o  out  DATA_W  oldest entry
- out_ready_i  in  1  scoreboard accepts
- count_o  out  $clog2(DEPTH+1)  entries held
- overflow_o  out  1  sticky: write attempted while in_ready_o=0

Behaviour:
- Reset (async, rst_i=1): rd/wr pointers=0, count_o=0, state RUN, out_valid_o=0, revert_done_o=0, revert_err_o=0, overflow_o=0, in_ready_o=1 once rst_i deasserts.
- Circular buffer. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count_o tracks occupancy exactly (0..DEPTH).
- Write: when in_ready_o=1, the valid channels are packed in ascending channel order into consecutive slots. count += popcount(in_valid_i). Gaps (e.g. valid=2'b10) produce no holes.
- Write while in_ready_o=0 with any valid bit set: data dropped, overflow_o set until reset.
- Output: out_valid_o = (count > REVERT_MAX) in RUN, or (count > 0) in FLUSH. out_data_o = entry at rd pointer, combinational from storage. A pop occurs when out_valid_o && out_ready_i: rd pointer +1, count -1.
- Revert, evaluated on revert_req_i:
  - Accepted iff state RUN, steps >= 1 and steps <= count. Out-of-range values (steps > REVERT_MAX with non-power-of-2 encoding) are rejected.
  - Accepted: wr pointer -= steps, count -= steps, revert_done_o=1 next cycle.
  - Rejected: no state change, revert_err_o=1 next cycle.
  - steps=0 is rejected.
- Same-cycle ordering: pop (on the pre-cycle state) -> revert -> write append.
  - Revert never removes entries written in the same cycle.
  - Revert is legal alongside a pop because a pop implies count > REVERT_MAX >= steps. The bound is checked against count minus pop.
  - Count update: count_next = count - pop - (accepted ? steps : 0) + writes. Never negative and never > DEPTH.
- FSM:
  - RUN -> FLUSH on flush_i.
  - In FLUSH: in_ready_o=0, every revert is rejected, and drain continues.
  - FLUSH -> RUN on the cycle count reaches 0 (including the same-cycle final pop).
  - flush_i while already in FLUSH has no effect.
  - flush_i with count=0: enters FLUSH for one cycle, then returns to RUN.
- Pulses: revert_done_o and revert_err_o are high for exactly one cycle and are mutually exclusive.
- Reset mid-operation (including mid-flush): all entries discarded, pulses cleared, state RUN.

Test Plan (NRET=2, DEPTH=8, REVERT_MAX=2, DATA_W=64):
- Write A,B (valid=2'b11), then C (valid=2'b10 carrying C on ch1); out_ready_i=1 -> count 3; out_valid_o rises when count=3; A popped; count settles at 2, B/C retained.
- Hold out_ready_i=0 and write 8 entries -> in_ready_o=0 at count 7; a further write sets overflow_o=1; count stays 8.
- count=4 (W,X,Y,Z), revert_steps_i=2 -> revert_done_o next cycle, count=2; next write E lands after X; drain order W,X,E after flush.
- count=1, revert_steps_i=2 -> revert_err_o=1 next cycle, count unchanged. Separately, revert_steps_i=0 -> revert_err_o=1.
- Same cycle: pop + revert 1 + write 2, starting from count=4 -> count=4; reverted slot overwritten by the first new entry.
- flush_i with count=2 -> in_ready_o=0, both entries drain, FSM returns to RUN when count=0. A revert issued mid-flush -> revert_err_o=1. rst_i asserted mid-flush -> count_o=0 asynchronously.
